// File: rtl/alarm_tone_seq.sv
`default_nettype none
// ============================================================================
// Module      : alarm_tone_seq
// Description : Alarm melody sequencer. Plays an eight-note melody as a
//               volume-scaled PWM square wave while the alarm input is high,
//               with a silent gap between notes and an off/mute request.
// Revision    : 1.0 - initial release
// ============================================================================
module alarm_tone_seq #(
    parameter int NOTE_TICKS = 12500000,
    parameter int GAP_TICKS  = 1250000,
    parameter int TONE_SHIFT = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       alarm_i,
    input  logic       off_i,
    input  logic [7:0] volume_i,
    output logic       aud_pwm,
    output logic       playing_o,
    output logic [2:0] note_idx_o
);

    // The duration counter is shared by PLAY and GAP, so size it for the longer
    localparam int c_MAX_TICKS = (NOTE_TICKS > GAP_TICKS) ? NOTE_TICKS : GAP_TICKS;
    localparam int c_DUR_W     = (c_MAX_TICKS > 1) ? $clog2(c_MAX_TICKS) : 1;
    localparam logic [c_DUR_W-1:0] c_NOTE_LAST = c_DUR_W'(NOTE_TICKS - 1);
    localparam logic [c_DUR_W-1:0] c_GAP_LAST  = c_DUR_W'(GAP_TICKS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PLAY  = 2'd1,
        ST_GAP   = 2'd2,
        ST_MUTED = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [2:0]          r_note_idx;
    logic [2:0]          w_note_idx_nxt;
    logic [c_DUR_W-1:0]  r_dur;
    logic [c_DUR_W-1:0]  w_dur_nxt;
    logic                r_alarm_q;
    logic                w_alarm_rise;
    logic [17:0]         r_tone_cnt;
    logic [17:0]         w_tone_cnt_nxt;
    logic                r_square;
    logic                w_square_nxt;
    logic [7:0]          r_pwm_cnt;
    logic [7:0]          w_pwm_cnt_nxt;
    logic [17:0]         w_rom_hp;
    logic [17:0]         w_hp_shift;
    logic [17:0]         w_half_period;
    logic                w_aud_nxt;
    logic                r_aud;
    logic                r_playing;

    assign w_alarm_rise  = alarm_i & ~r_alarm_q;
    assign w_pwm_cnt_nxt = r_pwm_cnt + 8'd1;
    assign aud_pwm       = r_aud;
    assign playing_o     = r_playing;
    assign note_idx_o    = r_note_idx;

    // Melody ROM lookup and effective half-period (never allowed to reach 0)
    always_comb begin
        w_rom_hp = 18'd47778;
        case (r_note_idx)
            3'd0:    w_rom_hp = 18'd95556;
            3'd1:    w_rom_hp = 18'd85131;
            3'd2:    w_rom_hp = 18'd75843;
            3'd3:    w_rom_hp = 18'd71586;
            3'd4:    w_rom_hp = 18'd63776;
            3'd5:    w_rom_hp = 18'd56818;
            3'd6:    w_rom_hp = 18'd50619;
            default: w_rom_hp = 18'd47778;
        endcase
        w_hp_shift    = w_rom_hp >> TONE_SHIFT;
        w_half_period = (w_hp_shift == 18'd0) ? 18'd1 : w_hp_shift;
    end

    // Next-state logic; off_i outranks alarm drop, which outranks note timing
    always_comb begin
        w_state_nxt    = r_state;
        w_note_idx_nxt = r_note_idx;
        w_dur_nxt      = r_dur;
        case (r_state)
            ST_IDLE: begin
                if (w_alarm_rise) begin
                    w_state_nxt    = ST_PLAY;
                    w_note_idx_nxt = 3'd0;
                    w_dur_nxt      = '0;
                end
            end
            ST_PLAY: begin
                if (off_i) begin
                    w_state_nxt = ST_MUTED;
                    w_dur_nxt   = '0;
                end else if (!alarm_i) begin
                    w_state_nxt    = ST_IDLE;
                    w_note_idx_nxt = 3'd0;
                    w_dur_nxt      = '0;
                end else if (r_dur == c_NOTE_LAST) begin
                    w_state_nxt = ST_GAP;
                    w_dur_nxt   = '0;
                end else begin
                    w_dur_nxt = r_dur + 1'b1;
                end
            end
            ST_GAP: begin
                if (off_i) begin
                    w_state_nxt = ST_MUTED;
                    w_dur_nxt   = '0;
                end else if (!alarm_i) begin
                    w_state_nxt    = ST_IDLE;
                    w_note_idx_nxt = 3'd0;
                    w_dur_nxt      = '0;
                end else if (r_dur == c_GAP_LAST) begin
                    w_state_nxt    = ST_PLAY;
                    w_note_idx_nxt = r_note_idx + 3'd1;
                    w_dur_nxt      = '0;
                end else begin
                    w_dur_nxt = r_dur + 1'b1;
                end
            end
            ST_MUTED: begin
                if (!alarm_i) begin
                    w_state_nxt    = ST_IDLE;
                    w_note_idx_nxt = 3'd0;
                    w_dur_nxt      = '0;
                end
            end
            default: begin
                w_state_nxt    = ST_IDLE;
                w_note_idx_nxt = 3'd0;
                w_dur_nxt      = '0;
            end
        endcase
    end

    // Tone generator runs only while remaining in PLAY, so it starts from zero on every note
    always_comb begin
        w_tone_cnt_nxt = '0;
        w_square_nxt   = 1'b0;
        if ((r_state == ST_PLAY) && (w_state_nxt == ST_PLAY)) begin
            if (r_tone_cnt == (w_half_period - 18'd1)) begin
                w_tone_cnt_nxt = '0;
                w_square_nxt   = ~r_square;
            end else begin
                w_tone_cnt_nxt = r_tone_cnt + 18'd1;
                w_square_nxt   = r_square;
            end
        end
        // Built from next values so the PWM output lines up with the state it reflects
        w_aud_nxt = (w_state_nxt == ST_PLAY) && w_square_nxt && (w_pwm_cnt_nxt < volume_i);
    end

    // State, counters and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_note_idx <= 3'd0;
            r_dur      <= '0;
            r_alarm_q  <= 1'b0;
            r_tone_cnt <= '0;
            r_square   <= 1'b0;
            r_pwm_cnt  <= 8'd0;
            r_aud      <= 1'b0;
            r_playing  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_note_idx <= w_note_idx_nxt;
            r_dur      <= w_dur_nxt;
            r_alarm_q  <= alarm_i;
            r_tone_cnt <= w_tone_cnt_nxt;
            r_square   <= w_square_nxt;
            r_pwm_cnt  <= w_pwm_cnt_nxt;
            r_aud      <= w_aud_nxt;
            r_playing  <= (w_state_nxt == ST_PLAY) || (w_state_nxt == ST_GAP);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alarm_tone_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_alarm_tone_seq
// Description : Scoreboard bench for alarm_tone_seq with a behavioural
//               melody-timeline reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alarm_tone_seq;

    localparam int NOTE_T = 20;
    localparam int GAP_T  = 4;
    localparam int SHIFT  = 12;
    localparam int PERIOD = NOTE_T + GAP_T;

    logic       clk = 1'b0;
    logic       rst;
    logic       alarm_i;
    logic       off_i;
    logic [7:0] volume_i;
    logic       aud_pwm;
    logic       playing_o;
    logic [2:0] note_idx_o;

    alarm_tone_seq #(
        .NOTE_TICKS (NOTE_T),
        .GAP_TICKS  (GAP_T),
        .TONE_SHIFT (SHIFT)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .alarm_i    (alarm_i),
        .off_i      (off_i),
        .volume_i   (volume_i),
        .aud_pwm    (aud_pwm),
        .playing_o  (playing_o),
        .note_idx_o (note_idx_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       aud;
        logic       play;
        logic [2:0] idx;
        int         tag;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   total   = 0;
    int   bad     = 0;
    int   tag     = 0;
    bit   started = 0;
    bit   done    = 0;

    // Reference model: mode 0=silent/idle, 1=melody running, 2=silenced by off
    int rom [8] = '{95556, 85131, 75843, 71586, 63776, 56818, 50619, 47778};
    int m_mode = 0;
    int m_idx  = 0;
    int m_t    = 0;     // cycle position within the current note+gap slot
    bit m_prev = 0;
    int m_cyc  = 0;     // cycles since reset, modulo 256

    function automatic int hp(input int i);
        int h;
        h = rom[i] >> SHIFT;
        if (h == 0) h = 1;
        return h;
    endfunction

    task automatic model_edge(input bit r, input bit a, input bit o);
        if (r) begin
            m_mode = 0; m_idx = 0; m_t = 0; m_prev = 0; m_cyc = 0;
        end else begin
            m_cyc = (m_cyc + 1) % 256;
            case (m_mode)
                0: if (a && !m_prev) begin m_mode = 1; m_idx = 0; m_t = 0; end
                1: begin
                    if (o) m_mode = 2;
                    else if (!a) begin m_mode = 0; m_idx = 0; end
                    else begin
                        m_t = m_t + 1;
                        if (m_t == PERIOD) begin m_t = 0; m_idx = (m_idx + 1) % 8; end
                    end
                end
                default: if (!a) begin m_mode = 0; m_idx = 0; end
            endcase
            m_prev = a;
        end
    endtask

    // One clock of stimulus: drive inputs, advance the model, queue the expectation
    task automatic step(input bit r, input bit a, input bit o, input logic [7:0] v);
        exp_t e;
        @(negedge clk);
        rst = r; alarm_i = a; off_i = o; volume_i = v;
        model_edge(r, a, o);
        e.play = (m_mode == 1);
        e.idx  = 3'(m_idx);
        e.aud  = (m_mode == 1) && (m_t < NOTE_T) && (((m_t / hp(m_idx)) % 2) == 1)
                 && (m_cyc < int'(v));
        e.tag  = tag;
        sb_q.push_back(e);
        started = 1;
    endtask

    // Hold alarm high until the model reaches a given note/slot position
    task automatic run_until(input int idx, input int t, input logic [7:0] v, input int budget);
        int n;
        n = 0;
        while (!(m_mode == 1 && m_idx == idx && m_t == t) && n < budget) begin
            step(0, 1, 0, v);
            n++;
        end
        if (n >= budget) begin
            total++; bad++;
            $display("FAIL run_until tag=%0d: position note=%0d t=%0d not reached within %0d cycles",
                     tag, idx, t, budget);
        end
    endtask

    // Monitor: compare every presented output cycle against the queued expectation
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                mon_e = sb_q.pop_front();
                total++;
                if (aud_pwm !== mon_e.aud || playing_o !== mon_e.play || note_idx_o !== mon_e.idx) begin
                    bad++;
                    $display("FAIL outputs tag=%0d t=%0t: got aud=%b play=%b idx=%0d, want aud=%b play=%b idx=%0d",
                             mon_e.tag, $time, aud_pwm, playing_o, note_idx_o,
                             mon_e.aud, mon_e.play, mon_e.idx);
                end
            end else if (started && !done) begin
                total++; bad++;
                $display("FAIL sb_underflow t=%0t: got no expectation, want one per cycle", $time);
            end
        end
    end

    initial begin
        bit         ra;
        bit         ro;
        bit         rr;
        logic [7:0] rv;
        rst = 1'b1; alarm_i = 1'b0; off_i = 1'b0; volume_i = 8'd0;

        tag = 1;    // reset state
        for (int i = 0; i < 3; i++) step(1, 0, 0, 8'd0);

        tag = 2;    // off in IDLE is ignored
        for (int i = 0; i < 2; i++) step(0, 0, 1, 8'd200);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 8'd200);

        tag = 3;    // full melody with wrap, volume 128 / 0 / 255
        for (int i = 0; i < PERIOD * 9 + 4; i++)
            step(0, 1, 0, (i < 48) ? 8'd128 : ((i < 96) ? 8'd0 : 8'd255));

        tag = 4;    // alarm drop returns to idle
        for (int i = 0; i < 3; i++) step(0, 0, 0, 8'd255);

        tag = 5;    // off during note 3, long hold stays silent, restart after drop
        run_until(3, 5, 8'd255, 400);
        step(0, 1, 1, 8'd255);
        for (int i = 0; i < 200; i++) step(0, 1, 0, 8'd255);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 8'd255);
        for (int i = 0; i < 30; i++) step(0, 1, 0, 8'd255);

        tag = 6;    // off coincident with gap end
        run_until(1, PERIOD - 1, 8'd255, 400);
        step(0, 1, 1, 8'd255);
        for (int i = 0; i < 10; i++) step(0, 1, 0, 8'd255);
        for (int i = 0; i < 2; i++) step(0, 0, 0, 8'd255);

        tag = 7;    // alarm drop during gap of note 5
        run_until(5, NOTE_T + 1, 8'd200, 400);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 8'd200);

        tag = 8;    // reset during note 2 with alarm held high
        run_until(2, 7, 8'd255, 400);
        for (int i = 0; i < 3; i++) step(1, 1, 0, 8'd255);
        for (int i = 0; i < 40; i++) step(0, 1, 0, 8'd255);

        tag = 9;    // randomized traffic
        ra = 1'b1;
        rv = 8'd100;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 99) == 0) ra = ~ra;
            if ($urandom_range(0, 49) == 0) rv = 8'($urandom_range(0, 255));
            ro = ($urandom_range(0, 149) == 0);
            rr = ($urandom_range(0, 499) == 0);
            step(rr, ra, ro, rv);
        end

        @(negedge clk);
        done = 1;
        @(negedge clk);
        if (sb_q.size() != 0) begin
            total++; bad++;
            $display("FAIL sb_drain: got %0d pending expectations, want 0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alarm_tone_seq.md
ALARM_TONE_SEQ -- requirements
Module: alarm_tone_seq

Interface
REQ-001 SHALL have parameter NOTE_TICKS, default 12500000, clk cycles per sounding note (250 ms at 50 MHz).
REQ-002 SHALL have parameter GAP_TICKS, default 1250000, silent clk cycles between consecutive notes.
REQ-003 SHALL have parameter TONE_SHIFT, default 0, right shift applied to every melody divider (test speed-up).
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port alarm_i  input  1  level; high while the alarm time matches and alarm is enabled.
REQ-007 SHALL have port off_i  input  1  one-cycle pulse; silences the current alarm.
REQ-008 SHALL have port volume_i  input  8  PWM duty for tone-high phase; 0 = mute.
REQ-009 SHALL have port aud_pwm  output  1  PWM audio to the speaker filter.
REQ-010 SHALL have port playing_o  output  1  high in PLAY or GAP.
REQ-011 SHALL have port note_idx_o  output  3  index of the current melody note.

Function
REQ-012 SHALL implement FSM states IDLE, PLAY, GAP, MUTED.
REQ-013 IDLE->PLAY on the rising edge of alarm_i (registered alarm_i low last cycle, high this cycle); note_idx cleared to 0, duration counter cleared.
REQ-014 PLAY: duration counter counts 0..NOTE_TICKS-1; at NOTE_TICKS-1 -> GAP, counter cleared.
REQ-015 GAP: counter counts 0..GAP_TICKS-1; at GAP_TICKS-1 -> PLAY with note_idx+1, wrapping 7->0 (3-bit wrap).
REQ-016 PLAY/GAP -> IDLE in the cycle after alarm_i is sampled low; note_idx cleared.
REQ-017 PLAY/GAP -> MUTED when off_i is high; off_i takes priority over every other transition in the same cycle.
REQ-018 MUTED -> IDLE only when alarm_i is sampled low; alarm_i staying high never restarts the melody.
REQ-019 off_i in IDLE or MUTED SHALL have no effect.
REQ-020 Melody ROM (18-bit half-period in clk cycles), idx 0..7: 95556, 85131, 75843, 71586, 63776, 56818, 50619, 47778.
REQ-021 Effective half-period HP = ROM[note_idx] >> TONE_SHIFT; if HP==0, HP SHALL be forced to 1.
REQ-022 Tone generator: 18-bit counter; at count HP-1 the square wave toggles and the counter clears; counter and square cleared on entering PLAY.
REQ-023 Tone counter and square SHALL hold at 0 outside PLAY.
REQ-024 PWM: free-running 8-bit counter pwm_cnt wrapping 255->0.
REQ-025 aud_pwm SHALL be registered: 1 iff state==PLAY and square==1 and pwm_cnt < volume_i; otherwise 0.
REQ-026 volume_i=255 SHALL give 255/256 duty during square-high; volume_i=0 SHALL keep aud_pwm at 0.
REQ-027 playing_o and note_idx_o SHALL be registered outputs of the FSM.
REQ-028 Counters SHALL be wide enough for NOTE_TICKS-1 and GAP_TICKS-1 without overflow (width from $clog2).

Reset
REQ-029 rst high SHALL, at the next clock edge, set state IDLE, note_idx 0, all counters 0, square 0, registered alarm_i 0.
REQ-030 During and after reset: aud_pwm=0, playing_o=0, note_idx_o=0.
REQ-031 Reset mid-PLAY SHALL abort the melody; with alarm_i still high after reset release, the registered-edge detector SHALL see a rising edge and restart at note 0.

Verification (NOTE_TICKS=20, GAP_TICKS=4, TONE_SHIFT=12)
REQ-032 Rise alarm_i, hold high -> playing_o=1 one cycle after edge seen; note_idx_o sequence 0..7,0 with period 24 cycles; note 0 HP=23 (95556>>12).
REQ-033 volume_i=128 during note 0 -> aud_pwm high only while square=1 and pwm_cnt<128; volume_i=0 -> aud_pwm constantly 0.
REQ-034 off_i pulse during note 3 PLAY -> next cycle MUTED, aud_pwm=0, playing_o=0; alarm_i held high 200 cycles -> stays silent; drop alarm_i -> IDLE; raise again -> restart at note 0.
REQ-035 off_i and GAP-end in the same cycle -> MUTED, note_idx_o not incremented.
REQ-036 alarm_i dropped during GAP of note 5 -> IDLE next cycle, note_idx_o=0, aud_pwm=0.
REQ-037 rst pulse during note 2 with alarm_i high -> outputs 0 while rst high; after release melody restarts at note 0.
